multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_pkg.sv | 24 ++
 rtl/multicycle_ctrl.sv | 124 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcode, state and datapath-select encodings shared by the multicycle controller.
package multicycle_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXEC    = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_ILLEGAL = 3'd5;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [1:0] A2_B      = 2'b00;
  localparam logic [1:0] A2_ONE    = 2'b01;
  localparam logic [1:0] A2_SIMM   = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle MIPS-style datapath.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           IRWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           ALUIn1Sel,
  output logic [1:0]     ALUIn2Sel,
  output logic [2:0]     ALUOp,
  output logic [1:0]     PCSel,
  output logic           WBSel,
  output logic           illegal
);
  logic [2:0]     state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           legal, is_lw;
  assign legal = opcode inside {OPW'(OP_RTYPE), OPW'(OP_ADDI), OPW'(OP_LW),
                                OPW'(OP_SW), OPW'(OP_BEQ), OPW'(OP_J)};
  assign is_lw = op_q == OPW'(OP_LW);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end
  // Outputs are a pure function of state, latched opcode, zero and mem_ready; rst forces them idle.
  always_comb begin
    state_d   = state_q;
    op_d      = state_q == S_DECODE ? opcode : op_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUIn1Sel = 1'b0;
    ALUIn2Sel = A2_B;
    ALUOp     = ALU_ADD;
    PCSel     = PC_ALU;
    WBSel     = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUIn2Sel = A2_ONE;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUIn2Sel = A2_SIMM;
        state_d   = legal ? S_EXEC : S_ILLEGAL;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OPW'(OP_RTYPE): begin
            ALUIn1Sel = 1'b1;
            ALUOp     = ALU_FUNCT;
            state_d   = S_WB;
          end
          OPW'(OP_ADDI): begin
            ALUIn1Sel = 1'b1;
            ALUIn2Sel = A2_SIMM;
            state_d   = S_WB;
          end
          OPW'(OP_LW), OPW'(OP_SW): begin
            ALUIn1Sel = 1'b1;
            ALUIn2Sel = A2_SIMM;
            state_d   = S_MEM;
          end
          OPW'(OP_BEQ): begin
            ALUIn1Sel = 1'b1;
            ALUOp     = ALU_SUB;
            PCSel     = PC_ALUOUT;
            PCWrite   = zero;
          end
          OPW'(OP_J): begin
            PCSel   = PC_JUMP;
            PCWrite = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = !is_lw;
        state_d  = !mem_ready ? S_MEM : is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        RegWrite = 1'b1;
        WBSel    = is_lw;
        state_d  = S_FETCH;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ALUIn1Sel = 1'b0;
      ALUIn2Sel = A2_B;
      ALUOp     = ALU_ADD;
      PCSel     = PC_ALU;
      WBSel     = 1'b0;
      illegal   = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: walks instructions as phase lists built from the instruction rules and checks every cycle's outputs.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUIn1Sel, WBSel, illegal;
  logic [1:0] ALUIn2Sel, PCSel;
  logic [2:0] ALUOp;
  int total = 0;
  int bad = 0;
  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PI = 5, PR = 6;
  localparam logic [5:0] RT = 6'b000000, AI = 6'b001000, LW = 6'b100011,
                         SW = 6'b101011, BQ = 6'b000100, JJ = 6'b000010;
  logic [5:0] legal_ops [6] = '{RT, AI, LW, SW, BQ, JJ};
  multicycle_ctrl #(.OPW(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUIn1Sel(ALUIn1Sel), .ALUIn2Sel(ALUIn2Sel), .ALUOp(ALUOp),
    .PCSel(PCSel), .WBSel(WBSel), .illegal(illegal)
  );
  always #5 clk = ~clk;
  // Packed order: PCWrite IRWrite MemRead MemWrite RegWrite ALUIn1Sel ALUIn2Sel ALUOp PCSel WBSel illegal
  function automatic logic [14:0] vec(logic pcw, logic irw, logic mrd, logic mwr, logic rw, logic a1,
                                      logic [1:0] a2, logic [2:0] aop, logic [1:0] pcs, logic wb, logic ill);
    return {pcw, irw, mrd, mwr, rw, a1, a2, aop, pcs, wb, ill};
  endfunction
  function automatic logic [14:0] expect_out(int ph, logic [5:0] op, logic z, logic mr);
    case (ph)
      PF: return vec(mr, mr, 1, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0);
      PD: return vec(0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 0, 0);
      PE: begin
        if (op == RT) return vec(0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0);
        if (op == BQ) return vec(z, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0, 0);
        if (op == JJ) return vec(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0, 0);
        return vec(0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0);
      end
      PM: return vec(0, 0, op == LW, op == SW, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
      PW: return vec(0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, op == LW, 0);
      PI: return vec(0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1);
      default: return '0;
    endcase
  endfunction
  // One clock: drive inputs, check outputs mid-cycle, then advance past the rising edge.
  task automatic step(int ph, logic [5:0] op, logic z, logic mr, logic [5:0] opin, string tag);
    logic [14:0] got, exp;
    zero = z;
    mem_ready = mr;
    opcode = opin;
    @(negedge clk);
    got = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUIn1Sel, ALUIn2Sel, ALUOp, PCSel, WBSel, illegal};
    exp = expect_out(ph, op, z, mr);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s ph=%0d op=%b got=%b exp=%b", tag, ph, op, got, exp);
    end
    @(posedge clk);
    #1;
  endtask
  // Phases for one instruction; opcode is only meaningful on the bus during FETCH and DECODE.
  task automatic run_instr(logic [5:0] op, logic z, int fwait, int mwait, string tag);
    int phs[$];
    logic [1:0] mrs[$];
    int n;
    for (int i = 0; i < fwait; i++) begin phs.push_back(PF); mrs.push_back(2'd0); end
    phs.push_back(PF); mrs.push_back(2'd1);
    phs.push_back(PD); mrs.push_back(2'd2);
    if (op != 6'b111111 && (op inside {RT, AI, LW, SW, BQ, JJ})) begin
      phs.push_back(PE); mrs.push_back(2'd2);
      if (op == LW || op == SW) begin
        for (int i = 0; i < mwait; i++) begin phs.push_back(PM); mrs.push_back(2'd0); end
        phs.push_back(PM); mrs.push_back(2'd1);
      end
      if (op == LW || op == RT || op == AI) begin phs.push_back(PW); mrs.push_back(2'd2); end
    end
    n = phs.size();
    for (int i = 0; i < n; i++) begin
      logic mr;
      logic [5:0] opin;
      mr = mrs[i] == 2'd2 ? 1'($urandom) : mrs[i][0];
      opin = (phs[i] == PF || phs[i] == PD) ? op : 6'($urandom);
      step(phs[i], op, phs[i] == PE ? z : 1'($urandom), mr, opin, tag);
    end
  endtask
  initial begin
    rst = 1'b1;
    step(PR, 6'd0, 0, 1, 6'd0, "reset0");
    step(PR, 6'd0, 1, 1, LW, "reset1");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(PF, 6'd0, 0, 0, 6'd0, "fetch_wait");
    run_instr(AI, 0, 0, 0, "addi");
    run_instr(LW, 0, 0, 3, "lw_wait3");
    run_instr(BQ, 1, 0, 0, "beq_taken");
    run_instr(BQ, 0, 0, 0, "beq_not");
    run_instr(RT, 0, 1, 0, "rtype");
    run_instr(SW, 0, 0, 2, "sw");
    run_instr(JJ, 0, 2, 0, "jump");
    for (int k = 0; k < 40; k++)
      run_instr(legal_ops[$urandom_range(5)], 1'($urandom), $urandom_range(2), $urandom_range(3), "rand");
    // Reset lands in the middle of a SW memory wait.
    run_instr(SW, 0, 0, 0, "sw_pre");
    step(PF, SW, 0, 1, SW, "sw_abort_f");
    step(PD, SW, 0, 0, SW, "sw_abort_d");
    step(PE, SW, 0, 0, 6'd0, "sw_abort_e");
    step(PM, SW, 0, 0, 6'd0, "sw_abort_m");
    rst = 1'b1;
    step(PR, SW, 0, 0, 6'd0, "sw_abort_rst");
    rst = 1'b0;
    step(PF, 6'd0, 0, 0, 6'd0, "sw_abort_after");
    step(PF, 6'd0, 0, 0, 6'd0, "sw_abort_after2");
    run_instr(AI, 0, 0, 0, "post_abort");
    for (int r = 0; r < 2; r++) begin
      logic [5:0] bop;
      bop = 6'b111111;
      if (r == 1) while (bop inside {RT, AI, LW, SW, BQ, JJ} || bop == 6'b111111) bop = 6'($urandom);
      step(PF, bop, 0, 1, bop, "ill_f");
      step(PD, bop, 0, 0, bop, "ill_d");
      for (int i = 0; i < 10; i++) step(PI, bop, 1'($urandom), 1'($urandom), 6'($urandom), "ill_hold");
      rst = 1'b1;
      step(PR, bop, 0, 1, 6'd0, "ill_rst");
      rst = 1'b0;
      step(PF, 6'd0, 0, 0, 6'd0, "ill_back");
      run_instr(JJ, 0, 0, 0, "ill_recover");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
